// File: rtl/nn_layer_sequencer_pkg.sv
// Shared types and helpers for the ANN layer/neuron sequencer.
// Also used by the weight-fetch block through nn_layer_size_lut.
package nn_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Upper bound on the packed LAYER_SIZES vector that layer_size() accepts.
  localparam int SIZES_MAX_W = 256;

  // Layers 1..4 = 30,30,10,10 (layer 1 sits in the least significant byte).
  localparam logic [31:0] DEFAULT_LAYER_SIZES = {8'd10, 8'd10, 8'd30, 8'd30};

  // Extract the size of layer k (1-based) from a packed sizes vector.
  // Out-of-range k (0 or beyond num_layers) yields 0.
  function automatic logic [31:0] layer_size(input logic [SIZES_MAX_W-1:0] sizes,
                                             input int k, input int neuron_w,
                                             input int num_layers);
    logic [SIZES_MAX_W-1:0] sh;
    logic [31:0]            mask;
    logic [31:0]            res;
    res  = 32'd0;
    mask = 32'hFFFF_FFFF >> (32 - neuron_w);
    if (k >= 1 && k <= num_layers) begin
      sh  = sizes >> ((k - 1) * neuron_w);
      res = sh[31:0] & mask;
    end else begin
      res = 32'd0;
    end
    return res;
  endfunction

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Beat bus between the sequencer (master) and the neuron compute / weight fetch (slave).
interface nn_layer_sequencer_if #(
  parameter int LAYER_W  = 8,
  parameter int NEURON_W = 8,
  parameter int ADDR_W   = 16
);
  logic                beat_valid;
  logic                beat_ready;
  logic [LAYER_W-1:0]  layer_num;
  logic [NEURON_W-1:0] neuron_num;
  logic                first_in_layer;
  logic                last_in_layer;
  logic                last_beat;
  logic [ADDR_W-1:0]   flat_idx;

  modport master (
    output beat_valid, layer_num, neuron_num, first_in_layer,
           last_in_layer, last_beat, flat_idx,
    input  beat_ready
  );

  modport slave (
    input  beat_valid, layer_num, neuron_num, first_in_layer,
           last_in_layer, last_beat, flat_idx,
    output beat_ready
  );
endinterface

// File: rtl/nn_layer_sequencer_lut.sv
// Combinational layer -> size lookup over the packed LAYER_SIZES parameter.
// Layer 0 or a layer beyond NUM_LAYERS maps to size 0.
module nn_layer_size_lut
  import nn_seq_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int LAYER_W    = 8,
  parameter int NEURON_W   = 8,
  parameter logic [NUM_LAYERS*NEURON_W-1:0] LAYER_SIZES = DEFAULT_LAYER_SIZES
) (
  input  logic [LAYER_W-1:0]  layer_i,
  output logic [NEURON_W-1:0] size_o
);
  localparam logic [SIZES_MAX_W-1:0] SIZES_EXT = SIZES_MAX_W'(LAYER_SIZES);

  // Select the entry for the requested layer.
  always_comb begin
    size_o = NEURON_W'(layer_size(SIZES_EXT, int'(layer_i), NEURON_W, NUM_LAYERS));
  end
endmodule

// File: rtl/nn_layer_sequencer.sv
// Layer/neuron sequencer: walks every (layer, neuron) pair of a parametrised
// topology once per started pass, one beat per valid/ready handshake.
// Optional: define NN_SEQ_FLAT_IDX_EN to generate the flat_idx counter.
module nn_layer_sequencer
  import nn_seq_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int LAYER_W    = 8,
  parameter int NEURON_W   = 8,
  parameter logic [NUM_LAYERS*NEURON_W-1:0] LAYER_SIZES = DEFAULT_LAYER_SIZES,
  parameter int ADDR_W     = 16
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  nn_layer_sequencer_if.master bus
);
  localparam logic [SIZES_MAX_W-1:0] SIZES_EXT = SIZES_MAX_W'(LAYER_SIZES);

  // Reject topologies that cannot be sequenced.
  if (NUM_LAYERS < 1) begin : g_bad_layers
    $error("nn_layer_sequencer: NUM_LAYERS must be >= 1");
  end
  if (NUM_LAYERS * NEURON_W > SIZES_MAX_W) begin : g_bad_width
    $error("nn_layer_sequencer: LAYER_SIZES wider than supported");
  end
  for (genvar k = 1; k <= NUM_LAYERS; k++) begin : g_size_chk
    if (layer_size(SIZES_EXT, k, NEURON_W, NUM_LAYERS) == 32'd0) begin : g_zero
      $error("nn_layer_sequencer: LAYER_SIZES entry of 0 is illegal");
    end
  end

  seq_state_e          state_q, state_d;
  logic [LAYER_W-1:0]  layer_q, layer_d;
  logic [NEURON_W-1:0] neuron_q, neuron_d;
  logic [NEURON_W-1:0] size_s;
  logic                valid_s, fire_s, last_in_s, last_layer_s;

  nn_layer_size_lut #(
    .NUM_LAYERS (NUM_LAYERS),
    .LAYER_W    (LAYER_W),
    .NEURON_W   (NEURON_W),
    .LAYER_SIZES(LAYER_SIZES)
  ) u_size_lut (
    .layer_i(layer_q),
    .size_o (size_s)
  );

  assign valid_s      = (state_q == ST_RUN);
  assign fire_s       = valid_s & bus.beat_ready;
  assign last_in_s    = (neuron_q == size_s);
  assign last_layer_s = (layer_q == LAYER_W'(NUM_LAYERS));

  // Next-state and counter update; abort always wins and clears the counters.
  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    neuron_d = neuron_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d  = ST_RUN;
          layer_d  = LAYER_W'(1);
          neuron_d = NEURON_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d  = ST_IDLE;
          layer_d  = '0;
          neuron_d = '0;
        end else if (fire_s) begin
          if (!last_in_s) begin
            neuron_d = neuron_q + NEURON_W'(1);
          end else if (!last_layer_s) begin
            layer_d  = layer_q + LAYER_W'(1);
            neuron_d = NEURON_W'(1);
          end else begin
            state_d  = ST_DONE;
            layer_d  = '0;
            neuron_d = '0;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        layer_d  = '0;
        neuron_d = '0;
      end
      default: begin
        state_d  = ST_IDLE;
        layer_d  = '0;
        neuron_d = '0;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q  <= ST_IDLE;
      layer_q  <= '0;
      neuron_q <= '0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      neuron_q <= neuron_d;
    end
  end

  assign busy               = (state_q != ST_IDLE);
  assign done               = (state_q == ST_DONE);
  assign bus.beat_valid     = valid_s;
  assign bus.layer_num      = layer_q;
  assign bus.neuron_num     = neuron_q;
  assign bus.first_in_layer = valid_s & (neuron_q == NEURON_W'(1));
  assign bus.last_in_layer  = valid_s & last_in_s;
  assign bus.last_beat      = valid_s & last_in_s & last_layer_s;

`ifdef NN_SEQ_FLAT_IDX_EN
  logic [ADDR_W-1:0] flat_q, flat_d;

  // Flat index: cleared on start/abort, advanced by each fired beat.
  always_comb begin
    flat_d = flat_q;
    if (abort || (state_q == ST_IDLE && start)) begin
      flat_d = '0;
    end else if (fire_s) begin
      flat_d = flat_q + ADDR_W'(1);
    end else begin
      flat_d = flat_q;
    end
  end

  // Flat index register.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      flat_q <= '0;
    end else begin
      flat_q <= flat_d;
    end
  end

  assign bus.flat_idx = flat_q;
`else
  assign bus.flat_idx = '0;
`endif
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed self-checking bench: default topology (dut0) and a 2-layer {1,3} topology (dut1).
module tb_nn_layer_sequencer;
  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic start0 = 1'b0, abort0 = 1'b0, busy0, done0;
  logic start1 = 1'b0, abort1 = 1'b0, busy1, done1;

  int checks = 0;
  int errors = 0;
  int sz[4] = '{30, 30, 10, 10};

  always #5 ACLK = ~ACLK;

  nn_layer_sequencer_if #(.LAYER_W(8), .NEURON_W(8), .ADDR_W(16)) bus0 ();
  nn_layer_sequencer_if #(.LAYER_W(8), .NEURON_W(8), .ADDR_W(16)) bus1 ();

  nn_layer_sequencer dut0 (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start0), .abort(abort0),
    .busy(busy0), .done(done0), .bus(bus0)
  );

  nn_layer_sequencer #(
    .NUM_LAYERS(2), .LAYER_W(8), .NEURON_W(8),
    .LAYER_SIZES({8'd1, 8'd3}), .ADDR_W(16)
  ) dut1 (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start1), .abort(abort1),
    .busy(busy1), .done(done1), .bus(bus1)
  );

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check one beat of dut0 against the expected (layer, neuron, flat) position.
  task automatic check_beat(input int l, input int n, input int flat);
    chk("valid", 32'(bus0.beat_valid), 32'd1);
    chk("layer", 32'(bus0.layer_num), 32'(l));
    chk("neuron", 32'(bus0.neuron_num), 32'(n));
    chk("first", 32'(bus0.first_in_layer), 32'(n == 1));
    chk("last_in", 32'(bus0.last_in_layer), 32'(n == sz[l-1]));
    chk("last_beat", 32'(bus0.last_beat), 32'(n == sz[l-1] && l == 4));
`ifdef NN_SEQ_FLAT_IDX_EN
    chk("flat_idx", 32'(bus0.flat_idx), 32'(flat));
`else
    chk("flat_idx", 32'(bus0.flat_idx), 32'(flat * 0));
`endif
  endtask

  // Walk a full pass of dut0 with beat_ready held high; returns with dut0 in DONE.
  task automatic full_pass();
    int f;
    f = 0;
    for (int l = 1; l <= 4; l++) begin
      for (int n = 1; n <= sz[l-1]; n++) begin
        check_beat(l, n, f);
        f++;
        step();
      end
    end
  endtask

  task automatic check_idle0(input string tag);
    chk({tag, "_busy"}, 32'(busy0), 32'd0);
    chk({tag, "_valid"}, 32'(bus0.beat_valid), 32'd0);
    chk({tag, "_layer"}, 32'(bus0.layer_num), 32'd0);
    chk({tag, "_neuron"}, 32'(bus0.neuron_num), 32'd0);
    chk({tag, "_done"}, 32'(done0), 32'd0);
  endtask

  initial begin
    int cnt, cyc, el, en;
    logic [3:0] pat;
    bus0.beat_ready = 1'b0;
    bus1.beat_ready = 1'b0;

    // Reset
    step();
    step();
    check_idle0("reset");
    chk("reset_first", 32'(bus0.first_in_layer), 32'd0);
    chk("reset_last_beat", 32'(bus0.last_beat), 32'd0);
    chk("reset_flat", 32'(bus0.flat_idx), 32'd0);
    chk("reset_busy1", 32'(busy1), 32'd0);
    ARESETN = 1'b1;
    step();
    check_idle0("idle_no_start");

    // Full pass, back-to-back beats
    start0 = 1'b1;
    bus0.beat_ready = 1'b1;
    step();
    start0 = 1'b0;
    full_pass();
    chk("done_pulse", 32'(done0), 32'd1);
    chk("done_busy", 32'(busy0), 32'd1);
    chk("done_valid", 32'(bus0.beat_valid), 32'd0);
    chk("done_layer", 32'(bus0.layer_num), 32'd0);
    step();
    check_idle0("after_done");

    // Backpressure: ready pattern 1,0,0,1
    pat = 4'b1001;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    cnt = 0; cyc = 0; el = 1; en = 1;
    while (cnt < 80 && cyc < 1000) begin
      bus0.beat_ready = pat[3 - (cyc % 4)];
      chk("bp_valid", 32'(bus0.beat_valid), 32'd1);
      chk("bp_layer", 32'(bus0.layer_num), 32'(el));
      chk("bp_neuron", 32'(bus0.neuron_num), 32'(en));
      if (bus0.beat_ready) begin
        cnt++;
        if (en < sz[el-1]) en++;
        else begin el++; en = 1; end
      end
      step();
      cyc++;
    end
    chk("bp_count", 32'(cnt), 32'd80);
    chk("bp_done", 32'(done0), 32'd1);
    step();
    check_idle0("bp_idle");

    // Abort on the cycle beat (2,5) fires
    bus0.beat_ready = 1'b1;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int i = 0; i < 34; i++) step();
    chk("pre_abort_layer", 32'(bus0.layer_num), 32'd2);
    chk("pre_abort_neuron", 32'(bus0.neuron_num), 32'd5);
    abort0 = 1'b1;
    step();
    abort0 = 1'b0;
    check_idle0("abort");
    step();
    check_idle0("abort_no_done");
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    check_beat(1, 1, 0);
    abort0 = 1'b1;
    step();
    abort0 = 1'b0;
    check_idle0("abort2");

    // start held high through RUN and DONE
    start0 = 1'b1;
    step();
    full_pass();
    chk("held_done", 32'(done0), 32'd1);
    step();
    check_idle0("held_idle");
    step();
    check_beat(1, 1, 0);
    start0 = 1'b0;
    abort0 = 1'b1;
    step();
    abort0 = 1'b0;
    check_idle0("held_abort");

    // Two-layer topology {1,3}: layer 1 = 3 neurons, layer 2 = 1 neuron
    bus1.beat_ready = 1'b1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      chk("t2_valid", 32'(bus1.beat_valid), 32'd1);
      chk("t2_layer", 32'(bus1.layer_num), 32'd1);
      chk("t2_neuron", 32'(bus1.neuron_num), 32'(n));
      chk("t2_first", 32'(bus1.first_in_layer), 32'(n == 1));
      chk("t2_last_in", 32'(bus1.last_in_layer), 32'(n == 3));
      chk("t2_last_beat", 32'(bus1.last_beat), 32'd0);
      step();
    end
    chk("t2_l2_layer", 32'(bus1.layer_num), 32'd2);
    chk("t2_l2_neuron", 32'(bus1.neuron_num), 32'd1);
    chk("t2_l2_first", 32'(bus1.first_in_layer), 32'd1);
    chk("t2_l2_last_in", 32'(bus1.last_in_layer), 32'd1);
    chk("t2_l2_last_beat", 32'(bus1.last_beat), 32'd1);
    step();
    chk("t2_done", 32'(done1), 32'd1);
    chk("t2_done_busy", 32'(busy1), 32'd1);
    step();
    chk("t2_idle_busy", 32'(busy1), 32'd0);
    chk("t2_idle_done", 32'(done1), 32'd0);

    // Synchronous reset mid-pass behaves like abort
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();
    ARESETN = 1'b0;
    step();
    ARESETN = 1'b1;
    check_idle0("midreset");
    chk("midreset_flat", 32'(bus0.flat_idx), 32'd0);
    step();
    check_idle0("midreset_no_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nn_layer_sequencer.md
Name: nn_layer_sequencer

Overview:
Parametrised layer/neuron sequencer for the ANN datapath; replaces the free-running fixed-topology traverser.
- Topology (layer count and per-layer neuron counts) is set by parameters.
- Each inference pass is started explicitly and emits one (layer, neuron) beat per valid/ready handshake.
- Each pass ends with a done pulse.
- It sits between the inference controller (start/abort) and the neuron compute unit / weight fetch (beat consumer).

Parameters:
NUM_LAYERS, 4, number of layers in the network (>=1)
LAYER_W, 8, width of layer_num
NEURON_W, 8, width of neuron_num and of each LAYER_SIZES entry
LAYER_SIZES, {8'd10,8'd10,8'd30,8'd30}, packed NUM_LAYERS*NEURON_W vector; layer k (1-based) size = LAYER_SIZES[(k-1)*NEURON_W +: NEURON_W]; default = 30,30,10,10 for layers 1..4
ADDR_W, 16, width of flat_idx (optional feature only)

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset, synchronous, active-low
start  in  1  begin a pass; sampled only in IDLE
abort  in  1  terminate current pass immediately, no done
beat_valid  out  1  layer_num/neuron_num hold a valid beat
beat_ready  in  1  consumer accepts beat
layer_num  out  LAYER_W  current layer, 1-based; 0 when not RUN
neuron_num  out  NEURON_W  current neuron, 1-based; 0 when not RUN
first_in_layer  out  1  beat is neuron 1 of its layer
last_in_layer  out  1  beat is final neuron of its layer
last_beat  out  1  beat is final neuron of final layer
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at pass completion
flat_idx  out  ADDR_W  optional; see Optional Feature

Behaviour:
- Reset (ARESETN=0 at ACLK edge):
  - state=IDLE.
  - All outputs 0, including flat_idx.
- States: IDLE, RUN, DONE.
- IDLE:
  - beat_valid=0, busy=0, layer_num=0, neuron_num=0.
  - start=1 and abort=0 -> RUN with layer=1, neuron=1; beat_valid=1 from the next cycle (1-cycle start latency).
  - start=1 with abort=1 -> remain IDLE.
- RUN:
  - beat_valid=1 continuously.
  - layer_num/neuron_num and all flags are stable while beat_valid=1 and beat_ready=0.
  - Beat fires on beat_valid & beat_ready. After a fired beat:
    - neuron < size(layer) -> neuron+1.
    - neuron == size(layer) and layer < NUM_LAYERS -> layer+1, neuron=1.
    - neuron == size(layer) and layer == NUM_LAYERS -> DONE.
  - Back-to-back: one beat per cycle when beat_ready is held high. Total beats per pass = sum of LAYER_SIZES entries (80 by default).
- DONE:
  - Lasts exactly one cycle: done=1, beat_valid=0, busy=1, layer_num=0, neuron_num=0.
  - Then IDLE. start during DONE is ignored.
- Flags are combinational from counters and gated by beat_valid:
  - first_in_layer = (neuron==1).
  - last_in_layer = (neuron==size(layer)).
  - last_beat = last_in_layer & (layer==NUM_LAYERS).
- abort:
  - abort=1 in RUN or DONE -> IDLE next cycle; no done pulse; counters cleared.
  - abort wins over a simultaneous fired beat; that beat counts as consumed but produces no further state.
- start while busy is ignored and is not queued.
- Size checks:
  - Any LAYER_SIZES entry of 0 is illegal; elaboration fails via a generate-time check.
  - Entries above 2^NEURON_W-1 cannot be expressed.
- Synchronous reset mid-pass returns to IDLE exactly like abort; no done.

Optional Feature:
Macro NN_SEQ_FLAT_IDX_EN.
- Defined:
  - flat_idx = 0-based global neuron index across all layers, i.e. sum of sizes of layers 1..layer-1 plus neuron-1.
  - Maintained as a counter: +1 per fired beat, cleared on start/abort/reset.
  - Used directly as the weight/bias memory base index.
- Undefined:
  - flat_idx is tied to 0 and no counter is generated.

Decomposition:
- Package nn_seq_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the default LAYER_SIZES constant;
  - a function layer_size(sizes, k) that extracts an entry.
- One natural sub-module, nn_layer_size_lut: maps layer_num to a size using LAYER_SIZES; combinational; shared with the weight-fetch block.
- Counters and FSM stay in the top.

Test Plan:
- Default params, reset, start pulse, beat_ready=1 -> 80 beats on consecutive cycles, beginning at (1,1) and ending at (4,10) with last_beat=1. Layer transitions go (1,30)->(2,1) and (2,30)->(3,1). done pulses once, 1 cycle after the final beat. busy drops the cycle after that.
- Backpressure: beat_ready toggles 1,0,0,1 repeatedly -> outputs are held during stalls and no beat is skipped or duplicated; the beat count is still 80.
- abort on the cycle beat (2,5) fires -> IDLE next cycle; no done; layer_num=neuron_num=0. A new start restarts at (1,1).
- start held high through RUN and DONE -> exactly one pass. With start still high in IDLE, a second pass begins the cycle after IDLE is entered.
- NUM_LAYERS=2, LAYER_SIZES={8'd1,8'd3} -> beats (1,1),(1,2),(1,3),(2,1). (2,1) shows first_in_layer, last_in_layer and last_beat all =1.
- NN_SEQ_FLAT_IDX_EN defined, default params -> flat_idx=0 at (1,1), 30 at (2,1), 60 at (3,1), 79 at (4,10).
